if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC and drives the
//  instruction ROM address. Captures ROM data into the IF/ID register. Applies stall,
//  flush and branch/jump redirects, and counts delivered instructions.
//  Sits between the hazard/branch logic (ID/EX) and the decode stage.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  EXC_VECTOR  32'h0000_0180  fetch-fault redirect target (IF_BAD_FETCH_EN only)
//  NOP_INSTR   32'h0000_0000  bubble instruction inserted on flush/fault
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   asynchronous, active-low reset
//  rom_addr      out  32  byte address to ROM (= pc; bits[1:0] always 0)
//  rom_data      in   32  instruction returned by ROM, combinational from rom_addr
//  stall         in   1   hazard unit: hold PC and IF/ID
//  br_taken      in   1   EX: branch resolved taken
//  br_target     in   32  EX: branch target byte address
//  jmp           in   1   ID: j instruction decoded
//  jmp_index     in   26  ID: j instr_index field
//  if_id_instr   out  32  IF/ID instruction
//  if_id_pc4     out  32  IF/ID PC+4 of that instruction
//  if_id_valid   out  1   IF/ID holds a real (non-bubble) instruction
//  fetch_fault   out  1   one-cycle pulse: bad fetch detected (IF_BAD_FETCH_EN only, else 0)
//  fetch_count   out  32  number of instructions delivered with valid=1
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC; if_id_instr=NOP_INSTR; if_id_pc4=0;
//   if_id_valid=0; fetch_fault=0; fetch_count=0; state=RUN.
//  First valid instruction appears in IF/ID on the first clk edge after rst_n deasserts.
//  rom_addr = {pc[31:2],2'b00} combinationally. Single-cycle fetch latency.
//  Next-PC priority, evaluated per edge (highest first):
//   1 br_taken:    pc<=br_target&~3; IF/ID<=bubble. Overrides jmp and stall.
//   2 jmp:         pc<={if_id_pc4[31:28],jmp_index,2'b00}; IF/ID<=bubble. Overrides stall.
//   3 stall:       pc and IF/ID hold; fetch_count holds.
//   4 default:     pc<=pc+4; IF/ID<={rom_data,pc+4,valid=1}; fetch_count++.
//  Bubble: if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc4 unchanged.
//  The jmp target uses the current if_id_pc4, i.e. the PC+4 of the j itself.
//  PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0. fetch_count wraps at 2^32.
//  FSM states:
//   RUN:      normal operation.
//   REDIRECT: entered for one cycle after any redirect. Its only effect is a status flag
//             for debug; fetch proceeds normally, i.e. a stall or new redirect is honoured.
//   FAULT:    IF_BAD_FETCH_EN only; see below.
//  FSM transitions: RUN->REDIRECT on redirect; REDIRECT->RUN otherwise.
//  Reset mid-redirect or mid-stall returns to RUN at RESET_PC with no residue.
// CONFIGURATION
//  IF_BAD_FETCH_EN defined:
//   - A default-case case (1 below) applies when rom_data==32'h8000_0000 (the ROM
//     unmapped-address word), !stall, !br_taken and !jmp.
//   - The fetch is discarded: IF/ID<=bubble, pc<=EXC_VECTOR, fetch_fault=1 for one
//     cycle, state=FAULT for one cycle, fetch_count unchanged.
//   - br_taken and jmp take priority over a fault.
//  IF_BAD_FETCH_EN undefined: 32'h8000_0000 is delivered as an ordinary instruction;
//   fetch_fault tied 0; no FAULT state.
// TESTING
//  1 Reset then 4 free-running cycles:
//    -> rom_addr 0,4,8,12; IF/ID pc4 4,8,12,16; valid=1; fetch_count=4.
//  2 stall=1 for 2 cycles at pc=0x10:
//    -> pc stays 0x10; IF/ID and fetch_count frozen; resumes at 0x14 after release.
//  3 br_taken=1, br_target=0x20, together with stall=1 and jmp=1:
//    -> pc=0x20 next edge; IF/ID bubble (valid=0); next fetch addr 0x20.
//  4 jmp with if_id_pc4=0x13C, jmp_index=0x4F:
//    -> pc=0x13C; IF/ID bubble; repeated jmp loops at 0x13C.
//  5 IF_BAD_FETCH_EN, pc=0x200 (ROM returns 0x8000_0000):
//    -> fetch_fault pulses 1; pc=0x180; valid=0; count unchanged.
//    Without the macro: instr 0x8000_0000 valid=1.
//  6 rst_n low mid-redirect (pc=0x40):
//    -> all outputs at reset values immediately; fetch restarts at 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, ROM address, IF/ID register, redirects and delivered-instruction count.
// Single-cycle fetch; stall holds PC/IF/ID. Define IF_BAD_FETCH_EN to trap the unmapped-ROM word to EXC_VECTOR.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
`ifdef IF_BAD_FETCH_EN
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
`endif
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [25:0] jmp_index,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        fetch_fault,
   output logic [31:0] fetch_count,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_FAULT    = 2'd2
   } state_e;

   logic [31:0] pc_q,    pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q,   pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] count_q, count_d;
   state_e      state_q, state_d;

   logic [31:0] pc_plus4;
   logic [31:0] jmp_target;

`ifdef IF_BAD_FETCH_EN
   localparam logic [31:0] BAD_FETCH_WORD = 32'h8000_0000;
   logic        fault_q, fault_d;
`endif

   assign pc_plus4   = pc_q + 32'd4;
   // The j sits in IF/ID while its target is formed, so if_id_pc4 is the j's own PC+4.
   assign jmp_target = {pc4_q[31:28], jmp_index, 2'b00};

   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      count_d = count_q;
      state_d = ST_RUN;
`ifdef IF_BAD_FETCH_EN
      fault_d = 1'b0;
`endif
      if (br_taken) begin
         pc_d    = br_target & ~32'd3;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         state_d = ST_REDIRECT;
      end else if (jmp) begin
         pc_d    = jmp_target;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         state_d = ST_REDIRECT;
      end else if (stall) begin
         state_d = ST_RUN;
`ifdef IF_BAD_FETCH_EN
      end else if (rom_data == BAD_FETCH_WORD) begin
         // Discard the fetched word and vector away; it is not counted as delivered.
         pc_d    = EXC_VECTOR & ~32'd3;
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
         fault_d = 1'b1;
         state_d = ST_FAULT;
`endif
      end else begin
         pc_d    = pc_plus4;
         instr_d = rom_data;
         pc4_d   = pc_plus4;
         valid_d = 1'b1;
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC & ~32'd3;
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         count_q <= 32'd0;
         state_q <= ST_RUN;
`ifdef IF_BAD_FETCH_EN
         fault_q <= 1'b0;
`endif
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         count_q <= count_d;
         state_q <= state_d;
`ifdef IF_BAD_FETCH_EN
         fault_q <= fault_d;
`endif
      end
   end

   assign rom_addr    = pc_q & ~32'd3;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;
   assign fetch_count = count_q;
   assign fsm_state   = state_q;
`ifdef IF_BAD_FETCH_EN
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized and directed bench for if_fetch_stage against a per-edge reference model.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [25:0] jmp_index;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fetch_fault;
   logic [31:0] fetch_count;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   localparam logic [1:0] S_RUN = 2'd0, S_REDIR = 2'd1, S_FAULT = 2'd2;

   if_fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
      .stall(stall), .br_taken(br_taken), .br_target(br_target),
      .jmp(jmp), .jmp_index(jmp_index), .if_id_instr(if_id_instr),
      .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_fault(fetch_fault),
      .fetch_count(fetch_count), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // ROM contents: a scrambled word per address, with the unmapped marker at 0x200.
   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      if (a == 32'h0000_0200) return 32'h8000_0000;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign rom_data = rom_fn(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: what the IF/ID view must be after each edge.
   logic [31:0] m_pc, m_instr, m_pc4, m_count;
   logic        m_valid, m_fault;
   logic [1:0]  m_state;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0; m_fault = 0; m_state = S_RUN;
      end else begin
         logic [31:0] word;
         logic        bad;
         word    = rom_fn(m_pc);
`ifdef IF_BAD_FETCH_EN
         bad     = (word == 32'h8000_0000);
`else
         bad     = 1'b0;
`endif
         m_fault = 0;
         if (br_taken) begin
            m_pc = {br_target[31:2], 2'b00}; m_instr = 0; m_valid = 0; m_state = S_REDIR;
         end else if (jmp) begin
            m_pc = {m_pc4[31:28], jmp_index, 2'b00}; m_instr = 0; m_valid = 0; m_state = S_REDIR;
         end else if (stall) begin
            m_state = S_RUN;
         end else if (bad) begin
            m_pc = 32'h180; m_instr = 0; m_valid = 0; m_fault = 1; m_state = S_FAULT;
         end else begin
            m_instr = word; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
            m_count = m_count + 1; m_state = S_RUN;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rom_addr",    rom_addr,    m_pc);
         chk("if_id_instr", if_id_instr, m_instr);
         chk("if_id_pc4",   if_id_pc4,   m_pc4);
         chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
         chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
         chk("fetch_count", fetch_count, m_count);
         chk("fsm_state",   {30'd0, fsm_state}, {30'd0, m_state});
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_index = 0;
   endtask

   initial begin
      logic [31:0] saved_count;
      rst_n = 0;
      idle_inputs();
      #12;
      chk("reset rom_addr", rom_addr, 32'h0);
      chk("reset valid", {31'd0, if_id_valid}, 32'd0);
      chk("reset count", fetch_count, 32'd0);
      chk("reset instr", if_id_instr, 32'h0);
      @(negedge clk);
      rst_n  = 1;
      cmp_en = 1;
      chk("t1 first addr", rom_addr, 32'h0);

      // Free-running fetch from reset.
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t1 rom_addr", rom_addr, 32'(4 * k));
         chk("t1 pc4", if_id_pc4, 32'(4 * k));
         chk("t1 valid", {31'd0, if_id_valid}, 32'd1);
      end
      chk("t1 count", fetch_count, 32'd4);

      // Stall two cycles at 0x10.
      stall = 1;
      tick(); tick();
      chk("t2 pc hold", rom_addr, 32'h10);
      chk("t2 pc4 hold", if_id_pc4, 32'h10);
      chk("t2 count hold", fetch_count, 32'd4);
      stall = 0;
      tick();
      chk("t2 resume addr", rom_addr, 32'h14);
      chk("t2 resume count", fetch_count, 32'd5);

      // Branch beats jmp and stall.
      br_taken = 1; br_target = 32'h20; stall = 1; jmp = 1; jmp_index = 26'h3FF;
      tick();
      idle_inputs();
      chk("t3 br addr", rom_addr, 32'h20);
      chk("t3 bubble", {31'd0, if_id_valid}, 32'd0);
      chk("t3 pc4 kept", if_id_pc4, 32'h14);
      chk("t3 state", {30'd0, fsm_state}, 32'd1);
      tick();
      chk("t3 next pc4", if_id_pc4, 32'h24);
      chk("t3 state run", {30'd0, fsm_state}, 32'd0);

      // Jump loops on itself.
      jmp = 1; jmp_index = 26'h4F;
      tick();
      chk("t4 jmp addr", rom_addr, 32'h13C);
      chk("t4 bubble", {31'd0, if_id_valid}, 32'd0);
      tick();
      chk("t4 jmp loop", rom_addr, 32'h13C);
      idle_inputs();

      // Unmapped ROM word at 0x200.
      br_taken = 1; br_target = 32'h203;
      tick();
      idle_inputs();
      chk("t5 masked br", rom_addr, 32'h200);
      saved_count = m_count;
      tick();
`ifdef IF_BAD_FETCH_EN
      chk("t5 fault pulse", {31'd0, fetch_fault}, 32'd1);
      chk("t5 exc addr", rom_addr, 32'h180);
      chk("t5 bubble", {31'd0, if_id_valid}, 32'd0);
      chk("t5 count kept", fetch_count, saved_count);
      tick();
      chk("t5 fault clear", {31'd0, fetch_fault}, 32'd0);
      chk("t5 after addr", rom_addr, 32'h184);
`else
      chk("t5 instr", if_id_instr, 32'h8000_0000);
      chk("t5 valid", {31'd0, if_id_valid}, 32'd1);
      chk("t5 count", fetch_count, saved_count + 1);
      chk("t5 fault tied", {31'd0, fetch_fault}, 32'd0);
`endif

      // PC wraps at 2^32.
      br_taken = 1; br_target = 32'hFFFF_FFFC;
      tick();
      idle_inputs();
      tick();
      chk("wrap addr", rom_addr, 32'h0);
      chk("wrap pc4", if_id_pc4, 32'h0);

      // Async reset while a redirect is in flight.
      br_taken = 1; br_target = 32'h40;
      tick();
      idle_inputs();
      chk("t6 pre addr", rom_addr, 32'h40);
      #1 rst_n = 0;
      #1;
      chk("t6 rst addr", rom_addr, 32'h0);
      chk("t6 rst pc4", if_id_pc4, 32'h0);
      chk("t6 rst count", fetch_count, 32'h0);
      chk("t6 rst state", {30'd0, fsm_state}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      tick();
      chk("t6 restart addr", rom_addr, 32'h4);
      chk("t6 restart instr", if_id_instr, rom_fn(32'h0));

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         stall     = ($urandom % 4) == 0;
         br_taken  = ($urandom % 12) == 0;
         br_target = ($urandom % 3 == 0) ? 32'(32'h1F0 + $urandom_range(0, 31)) : $urandom;
         jmp       = ($urandom % 10) == 0;
         jmp_index = 26'($urandom);
         if ($urandom % 250 == 0) begin
            #1 rst_n = 0;
            #2 rst_n = 1;
         end
         tick();
      end
      idle_inputs();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
